// File: rtl/vga_pixel_fetch_if.sv
// Image-RAM read bus between vga_pixel_fetch (master) and the image RAM (slave).
// Read data is valid one clock after a cycle with mem_rd=1.
interface vga_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;

  modport master (output mem_addr, output mem_rd, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata);
endinterface

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: turns the VGA scan position into image-RAM addresses and
// returns the grey pixel, with sync/blank delayed to stay aligned (2 cycles).
// The image (W x H, replicated SCALE x SCALE) sits at (X_OFFSET, Y_OFFSET).
// Optional feature: define BORDER_EN to draw a 1-pixel 8'hFF ring around it.
module vga_pixel_fetch #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned X_OFFSET = 192,
  parameter int unsigned Y_OFFSET = 112,
  parameter int unsigned SCALE    = 1,
  parameter logic [7:0]  BG_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              frame_start,
  input  logic [15:0]       dimensiones,
  vga_pixel_fetch_if.master mem,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_n_out
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DONE       = 2'd2
  } state_t;

  localparam logic [11:0] X0       = 12'(X_OFFSET);
  localparam logic [11:0] Y0       = 12'(Y_OFFSET);
  localparam logic [11:0] SC       = 12'(SCALE);
  localparam logic [1:0]  SCALE_M1 = 2'(SCALE - 1);

  state_t            state, state_nxt;
  logic [7:0]        w_m1;
  logic [8:0]        img_w;
  logic [11:0]       x_last, y_last;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]        col;
  logic [1:0]        hrep, vrep;
  logic [11:0]       x_ext, y_ext;
  logic              in_rect, in_region, row_end, img_end;
  logic              region_d1, region_d2, von_d1, von_d2;
  logic              hs_d1, hs_d2, vs_d1, vs_d2, ring_d2;

  assign x_ext = {2'b00, pixel_x};
  assign y_ext = {2'b00, pixel_y};
  assign img_w = {1'b0, w_m1} + 9'd1;

  // Geometric rectangle on the latched dimensions; fetching also needs ACTIVE
  // and loses to a simultaneous frame_start.
  assign in_rect   = video_on && (x_ext >= X0) && (x_ext <= x_last)
                     && (y_ext >= Y0) && (y_ext <= y_last);
  assign in_region = in_rect && (state == ACTIVE) && !frame_start;
  // A row also ends at the right screen edge when the image is clipped there.
  assign row_end   = (x_ext == x_last) || (pixel_x == 10'd639);
  assign img_end   = row_end && ((y_ext == y_last) || (pixel_y == 10'd479));

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_FRAME;
    else        state <= state_nxt;
  end

  // FSM next state: frame_start restarts from anywhere; last image pixel ends it
  always_comb begin
    state_nxt = state;
    if (frame_start)               state_nxt = ACTIVE;
    else if (in_region && img_end) state_nxt = DONE;
  end

  // Shadow dimensions and incremental address counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_m1     <= '0;
      x_last   <= '0;
      y_last   <= '0;
      row_base <= '0;
      col      <= '0;
      hrep     <= '0;
      vrep     <= '0;
    end else if (frame_start) begin
      w_m1     <= dimensiones[15:8];
      x_last   <= X0 + ({4'd0, dimensiones[15:8]} + 12'd1) * SC - 12'd1;
      y_last   <= Y0 + ({4'd0, dimensiones[7:0]} + 12'd1) * SC - 12'd1;
      row_base <= '0;
      col      <= '0;
      hrep     <= '0;
      vrep     <= '0;
    end else if (in_region) begin
      if (row_end) begin
        col  <= '0;
        hrep <= '0;
        if (vrep == SCALE_M1) begin
          vrep     <= '0;
          row_base <= row_base + ADDR_W'(img_w);
        end else begin
          vrep <= vrep + 2'd1;
        end
      end else if (hrep == SCALE_M1) begin
        hrep <= '0;
        col  <= col + 8'd1;
      end else begin
        hrep <= hrep + 2'd1;
      end
    end
  end

  // Read request (E0) and the two-stage delay of sync/blank/region flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem.mem_addr <= '0;
      mem.mem_rd   <= 1'b0;
      region_d1    <= 1'b0;
      region_d2    <= 1'b0;
      von_d1       <= 1'b0;
      von_d2       <= 1'b0;
      hs_d1        <= 1'b1;
      hs_d2        <= 1'b1;
      vs_d1        <= 1'b1;
      vs_d2        <= 1'b1;
    end else begin
      mem.mem_rd <= in_region;
      if (in_region) mem.mem_addr <= row_base + ADDR_W'(col);
      region_d1 <= in_region;
      region_d2 <= region_d1;
      von_d1    <= video_on;
      von_d2    <= von_d1;
      hs_d1     <= hsync_in;
      hs_d2     <= hs_d1;
      vs_d1     <= vsync_in;
      vs_d2     <= vs_d1;
    end
  end

`ifdef BORDER_EN
  logic on_ring, ring_d1;

  assign on_ring = (state != WAIT_FRAME) && video_on && !in_rect
                   && (x_ext + 12'd1 >= X0) && (x_ext <= x_last + 12'd1)
                   && (y_ext + 12'd1 >= Y0) && (y_ext <= y_last + 12'd1);

  // Delay the ring flag to line up with the pixel mux
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ring_d1 <= 1'b0;
      ring_d2 <= 1'b0;
    end else begin
      ring_d1 <= on_ring;
      ring_d2 <= ring_d1;
    end
  end
`else
  assign ring_d2 = 1'b0;
`endif

  // Output stage (E2): pixel mux plus aligned sync/blank
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blank_n_out <= 1'b0;
    end else begin
      hsync_out   <= hs_d2;
      vsync_out   <= vs_d2;
      blank_n_out <= von_d2;
      pixel_valid <= region_d2;
      if (!von_d2)        pixel <= '0;
      else if (region_d2) pixel <= mem.mem_rdata;
      else if (ring_d2)   pixel <= '1;
      else                pixel <= BG_VALUE;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Testbench for vga_pixel_fetch: two instances (SCALE=1 and SCALE=2) share the
// scan inputs; each has its own RAM bus. A position-based reference model
// (address = (row/S)*W + col/S) predicts every output.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;
  localparam int         X0 = 192;
  localparam int         Y0 = 112;
  localparam logic [7:0] BG = 8'h5A;
`ifdef BORDER_EN
  localparam logic [7:0] RING = 8'hFF;
`else
  localparam logic [7:0] RING = BG;
`endif

  typedef struct packed {
    logic [7:0] pix;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       blank;
  } out_t;

  typedef struct {
    logic        fs;
    int          x;
    int          y;
    logic [15:0] dims;
    logic        rd0;
    logic [15:0] a0;
    logic        rd1;
    logic [15:0] a1;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, frame_start = 1'b0;
  logic [15:0] dimensiones = '0;
  logic [7:0]  pix [2];
  logic        valid [2], hso [2], vso [2], blk [2];

  logic [7:0]  ram [0:65535];
  int          checks = 0, errors = 0;

  bit          started [2], done_f [2];
  int          mw [2], mh [2];
  logic [15:0] last_addr [2];
  out_t        p1 [2], p2 [2];

  vga_pixel_fetch_if #(.ADDR_W(16)) bus0 ();
  vga_pixel_fetch_if #(.ADDR_W(16)) bus1 ();

  vga_pixel_fetch #(.ADDR_W(16), .X_OFFSET(X0), .Y_OFFSET(Y0), .SCALE(1), .BG_VALUE(BG)) dut0 (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .dimensiones(dimensiones), .mem(bus0), .pixel(pix[0]), .pixel_valid(valid[0]),
    .hsync_out(hso[0]), .vsync_out(vso[0]), .blank_n_out(blk[0]));

  vga_pixel_fetch #(.ADDR_W(16), .X_OFFSET(X0), .Y_OFFSET(Y0), .SCALE(2), .BG_VALUE(BG)) dut1 (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .dimensiones(dimensiones), .mem(bus1), .pixel(pix[1]), .pixel_valid(valid[1]),
    .hsync_out(hso[1]), .vsync_out(vso[1]), .blank_n_out(blk[1]));

  always #5 clk = ~clk;

  // Synchronous image RAMs, one read port per instance
  always @(posedge clk) begin
    if (bus0.mem_rd) bus0.mem_rdata <= ram[bus0.mem_addr];
    if (bus1.mem_rd) bus1.mem_rdata <= ram[bus1.mem_addr];
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t mk(logic fs, int x, int y, logic [15:0] dims,
                              logic r0, int a0, logic r1, int a1);
    vec_t v;
    v.fs = fs; v.x = x; v.y = y; v.dims = dims;
    v.rd0 = r0; v.a0 = 16'(a0); v.rd1 = r1; v.a1 = 16'(a1);
    return v;
  endfunction

  task automatic model_reset();
    out_t r;
    r.pix = 8'h00; r.valid = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.blank = 1'b0;
    for (int d = 0; d < 2; d++) begin
      started[d] = 0; done_f[d] = 0; mw[d] = 0; mh[d] = 0;
      last_addr[d] = '0; p1[d] = r; p2[d] = r;
    end
  endtask

  // Reference model for instance d: predicts this cycle's read and the
  // outputs due now (from the sample two cycles earlier).
  task automatic model(input int d, output logic erd, output logic [15:0] eaddr, output out_t eo);
    int s, x, y, xe, ye, a;
    bit rect, region, ring;
    out_t o;
    s = d + 1;
    x = int'(pixel_x);
    y = int'(pixel_y);
    xe = X0 + mw[d] * s;
    ye = Y0 + mh[d] * s;
    rect   = video_on && x >= X0 && x < xe && y >= Y0 && y < ye;
    region = rect && started[d] && !done_f[d] && !frame_start;
    ring   = started[d] && video_on && !rect && x >= X0 - 1 && x <= xe && y >= Y0 - 1 && y <= ye;
    a = 0;
    if (region) begin
      a = ((y - Y0) / s) * mw[d] + (x - X0) / s;
      last_addr[d] = 16'(a);
    end
    erd = region;
    eaddr = last_addr[d];
    o.hs = hsync_in; o.vs = vsync_in; o.blank = video_on; o.valid = region;
    if (!video_on)   o.pix = 8'h00;
    else if (region) o.pix = ram[a];
    else if (ring)   o.pix = RING;
    else             o.pix = BG;
    eo = p2[d];
    p2[d] = p1[d];
    p1[d] = o;
    if (frame_start) begin
      started[d] = 1; done_f[d] = 0;
      mw[d] = int'(dimensiones[15:8]) + 1;
      mh[d] = int'(dimensiones[7:0]) + 1;
    end else if (region && x == xe - 1 && y == ye - 1) begin
      done_f[d] = 1;
    end
  endtask

  task automatic step(input logic fs, input logic von, input logic hs, input logic vs,
                      input int x, input int y, input logic [15:0] dims);
    logic erd [2];
    logic [15:0] ea [2];
    out_t eo [2];
    frame_start = fs; video_on = von; hsync_in = hs; vsync_in = vs;
    pixel_x = 10'(x); pixel_y = 10'(y); dimensiones = dims;
    for (int d = 0; d < 2; d++) model(d, erd[d], ea[d], eo[d]);
    @(posedge clk);
    #1;
    chk("mem_rd0", 32'(bus0.mem_rd), 32'(erd[0]));
    chk("mem_addr0", 32'(bus0.mem_addr), 32'(ea[0]));
    chk("mem_rd1", 32'(bus1.mem_rd), 32'(erd[1]));
    chk("mem_addr1", 32'(bus1.mem_addr), 32'(ea[1]));
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pixel%0d", d), 32'(pix[d]), 32'(eo[d].pix));
      chk($sformatf("valid_hs_vs_blank%0d", d), 32'({valid[d], hso[d], vso[d], blk[d]}),
          32'({eo[d].valid, eo[d].hs, eo[d].vs, eo[d].blank}));
    end
  endtask

  vec_t tbl [$];
  int   w, h, abort_at, n;
  bit   stop, fsb;
  logic [15:0] junk;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd", 32'({bus0.mem_rd, bus1.mem_rd}), 32'd0);
    chk("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
    chk("rst_pixel", 32'({pix[0], pix[1]}), 32'd0);
    chk("rst_flags", 32'({valid[0], hso[0], vso[0], blk[0]}), 32'b0110);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // 4x4 image: SCALE=1 on dut0, SCALE=2 on dut1; dims change mid-frame from row 113
    tbl.push_back(mk(1,   0, 100, 16'h0303, 0,  0, 0, 0));
    tbl.push_back(mk(0, 191, 112, 16'h0303, 0,  0, 0, 0));
    tbl.push_back(mk(0, 192, 112, 16'h0303, 1,  0, 1, 0));
    tbl.push_back(mk(0, 193, 112, 16'h0303, 1,  1, 1, 0));
    tbl.push_back(mk(0, 194, 112, 16'h0303, 1,  2, 1, 1));
    tbl.push_back(mk(0, 195, 112, 16'h0303, 1,  3, 1, 1));
    tbl.push_back(mk(0, 196, 112, 16'h0303, 0,  3, 1, 2));
    tbl.push_back(mk(0, 197, 112, 16'h0303, 0,  3, 1, 2));
    tbl.push_back(mk(0, 198, 112, 16'h0303, 0,  3, 1, 3));
    tbl.push_back(mk(0, 199, 112, 16'h0303, 0,  3, 1, 3));
    tbl.push_back(mk(0, 200, 112, 16'h0303, 0,  3, 0, 3));
    tbl.push_back(mk(0, 191, 113, 16'h0707, 0,  3, 0, 3));
    tbl.push_back(mk(0, 192, 113, 16'h0707, 1,  4, 1, 0));
    tbl.push_back(mk(0, 193, 113, 16'h0707, 1,  5, 1, 0));
    tbl.push_back(mk(0, 194, 113, 16'h0707, 1,  6, 1, 1));
    tbl.push_back(mk(0, 195, 113, 16'h0707, 1,  7, 1, 1));
    tbl.push_back(mk(0, 196, 113, 16'h0707, 0,  7, 1, 2));
    tbl.push_back(mk(0, 197, 113, 16'h0707, 0,  7, 1, 2));
    tbl.push_back(mk(0, 198, 113, 16'h0707, 0,  7, 1, 3));
    tbl.push_back(mk(0, 199, 113, 16'h0707, 0,  7, 1, 3));
    tbl.push_back(mk(0, 192, 114, 16'h0707, 1,  8, 1, 4));
    tbl.push_back(mk(0, 193, 114, 16'h0707, 1,  9, 1, 4));
    tbl.push_back(mk(0, 194, 114, 16'h0707, 1, 10, 1, 5));
    tbl.push_back(mk(0, 195, 114, 16'h0707, 1, 11, 1, 5));
    tbl.push_back(mk(0, 196, 114, 16'h0707, 0, 11, 1, 6));
    tbl.push_back(mk(0, 197, 114, 16'h0707, 0, 11, 1, 6));
    tbl.push_back(mk(0, 198, 114, 16'h0707, 0, 11, 1, 7));
    tbl.push_back(mk(0, 199, 114, 16'h0707, 0, 11, 1, 7));
    foreach (tbl[i]) begin
      step(tbl[i].fs, !tbl[i].fs, tbl[i].x[0], tbl[i].x[1], tbl[i].x, tbl[i].y, tbl[i].dims);
      chk($sformatf("tbl%0d_rd0", i), 32'(bus0.mem_rd), 32'(tbl[i].rd0));
      chk($sformatf("tbl%0d_a0", i), 32'(bus0.mem_addr), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d_rd1", i), 32'(bus1.mem_rd), 32'(tbl[i].rd1));
      chk($sformatf("tbl%0d_a1", i), 32'(bus1.mem_addr), 32'(tbl[i].a1));
    end

    // Finish both images in raster order; dut0 ends at address 15 on row 115
    for (int y = 115; y <= 120; y++) begin
      for (int x = 191; x <= 200; x++) begin
        step(0, 1, rb(), rb(), x, y, 16'h0707);
        if (y == 115 && x >= 192 && x <= 195)
          chk("last_row_addr0", 32'(bus0.mem_addr), 32'(x - 192 + 12));
      end
    end
    // Both done: revisiting the image area must not read
    for (int x = 192; x <= 195; x++) begin
      step(0, 1, 1, 1, x, 112, 16'h0707);
      chk("done_rd", 32'({bus0.mem_rd, bus1.mem_rd}), 32'd0);
      chk("done_addr0", 32'(bus0.mem_addr), 32'd15);
      chk("done_addr1", 32'(bus1.mem_addr), 32'd15);
    end

    // Asynchronous reset in the middle of an in-region run
    step(1, 0, 1, 1, 0, 100, 16'h0303);
    step(0, 1, 0, 1, X0 - 1, Y0, 16'h0303);
    step(0, 1, 0, 1, X0, Y0, 16'h0303);
    step(0, 1, 0, 1, X0 + 1, Y0, 16'h0303);
    chk("pre_rst_rd", 32'(bus0.mem_rd), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_rd", 32'({bus0.mem_rd, bus1.mem_rd}), 32'd0);
    chk("mid_rst_pixel", 32'(pix[0]), 32'd0);
    chk("mid_rst_flags", 32'({valid[0], hso[0], vso[0], blk[0]}), 32'b0110);
    @(posedge clk);
    #1;
    chk("mid_rst_next_rd", 32'(bus0.mem_rd), 32'd0);
    chk("mid_rst_next_flags", 32'({valid[1], hso[1], vso[1], blk[1]}), 32'b0110);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Randomized frames: random size, sync, mid-frame dims noise and occasional restarts
    for (int f = 0; f < 24; f++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 5);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 150) : -1;
      n = 0;
      stop = 0;
      step(1, 0, rb(), rb(), $urandom_range(0, 639), $urandom_range(0, 100),
           {8'(w - 1), 8'(h - 1)});
      for (int y = Y0 - 2; y <= Y0 + h * 2 + 1 && !stop; y++) begin
        junk = 16'($urandom);
        for (int x = X0 - 3; x <= X0 + w * 2 + 2 && !stop; x++) begin
          fsb = (n == abort_at);
          step(fsb, 1, rb(), rb(), x, y, junk);
          n++;
          if (fsb) stop = 1;
        end
        for (int g = 0; g < 3 && !stop; g++)
          step(0, 0, rb(), rb(), $urandom_range(0, 639), y, junk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
